// File: rtl/rr_sel_arbiter.sv
// Four-channel round-robin arbiter that drives a registered 4:1 mux select.
// A grant is held until done, request withdrawal, or HOLD_MAX cycles elapse.
module rr_sel_arbiter #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] s,
    output logic [3:0] gnt,
    output logic       valid,
    output logic       timeout
);

    localparam logic       ST_IDLE   = 1'b0;
    localparam logic       ST_GRANT  = 1'b1;
    localparam logic [7:0] HCNT_LAST = 8'(HOLD_MAX - 1);

    logic       state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;
    logic       timeout_q, timeout_d;

    logic [1:0] win;
    logic       at_limit;
    logic       withdrawn;
    logic       release_grant;

    // Walk the offsets from far to near so the closest set bit after ptr wins.
    always_comb begin
        win = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
        end
    end

    assign at_limit      = (hcnt_q == HCNT_LAST);
    assign withdrawn     = !req[idx_q];
    assign release_grant = done || withdrawn || at_limit;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves one unassigned and infers a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hcnt_d    = hcnt_q;
        gnt_d     = gnt_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;

        if (state_q == ST_IDLE) begin
            if (req != 4'b0000) begin
                state_d = ST_GRANT;
                idx_d   = win;
                hcnt_d  = 8'd0;
                gnt_d   = 4'b0001 << win;
                valid_d = 1'b1;
            end
        end else begin
            if (release_grant) begin
                // A limit hit only counts as a timeout when nothing else ended the grant.
                state_d   = ST_IDLE;
                ptr_d     = idx_q + 2'd1;
                gnt_d     = 4'b0000;
                valid_d   = 1'b0;
                timeout_d = at_limit && !done && !withdrawn;
            end else begin
                hcnt_d = hcnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            idx_q     <= 2'd0;
            hcnt_q    <= 8'd0;
            gnt_q     <= 4'b0000;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hcnt_q    <= hcnt_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // idx only changes on arbitration, so it doubles as the held select.
    assign s       = idx_q;
    assign gnt     = gnt_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: directed vectors, corner sequences and a
// randomized run against a holder/cycle-count reference model.
module tb_rr_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;

    // Instance 0: HOLD_MAX=15, 1: HOLD_MAX=4, 2: HOLD_MAX=1
    logic [2:0][1:0] s_w;
    logic [2:0][3:0] gnt_w;
    logic [2:0]      valid_w;
    logic [2:0]      tmo_w;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    rr_sel_arbiter #(.HOLD_MAX(15)) dut15 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .s(s_w[0]), .gnt(gnt_w[0]), .valid(valid_w[0]), .timeout(tmo_w[0])
    );
    rr_sel_arbiter #(.HOLD_MAX(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .s(s_w[1]), .gnt(gnt_w[1]), .valid(valid_w[1]), .timeout(tmo_w[1])
    );
    rr_sel_arbiter #(.HOLD_MAX(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .s(s_w[2]), .gnt(gnt_w[2]), .valid(valid_w[2]), .timeout(tmo_w[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs {gnt, s, valid, timeout} of one instance.
    function automatic logic [7:0] outs(input int k);
        return {gnt_w[k], s_w[k], valid_w[k], tmo_w[k]};
    endfunction

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] s;
        logic       valid;
        logic       timeout;
    } vec_t;

    vec_t vecs[22];

    // Reference model: who holds the grant, how many cycles it has held, where the next search starts.
    int hm[3] = '{15, 4, 1};
    int holder[3];
    int held[3];
    int nxt[3];
    int sel[3];
    int tmo[3];

    task automatic model_step(input int k);
        if (rst) begin
            holder[k] = -1; held[k] = 0; nxt[k] = 0; sel[k] = 0; tmo[k] = 0;
        end else if (holder[k] < 0) begin
            tmo[k] = 0;
            for (int j = 0; j < 4; j++) begin
                int c;
                c = (nxt[k] + j) % 4;
                if (req[c]) begin
                    holder[k] = c; sel[k] = c; held[k] = 1;
                    break;
                end
            end
        end else if (done || !req[holder[k]] || held[k] == hm[k]) begin
            tmo[k]    = (held[k] == hm[k] && !done && req[holder[k]]) ? 1 : 0;
            nxt[k]    = (holder[k] + 1) % 4;
            holder[k] = -1;
        end else begin
            held[k]++;
        end
    endtask

    function automatic logic [7:0] model_outs(input int k);
        logic [3:0] g;
        g = (holder[k] >= 0) ? 4'(1 << holder[k]) : 4'b0000;
        return {g, 2'(sel[k]), (holder[k] >= 0), tmo[k][0]};
    endfunction

    initial begin
        // HOLD_MAX=4 instance: reset, basic grant, timeout, done at limit, withdrawal wrap, reset mid-grant.
        vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 4'b0010, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 4'b1010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};

        tick();
        for (int i = 0; i < 22; i++) begin
            rst  = vecs[i].rst;
            req  = vecs[i].req;
            done = vecs[i].done;
            tick();
            check($sformatf("vec%0d", i), 32'(outs(1)),
                  32'({vecs[i].gnt, vecs[i].s, vecs[i].valid, vecs[i].timeout}));
        end

        // Rotation with all channels requesting, done on each grant's second cycle (HOLD_MAX=15).
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        tick();
        rst = 1'b0; req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            done = 1'b0;
            tick();
            check($sformatf("rot%0d_c1", g), 32'(outs(0)), 32'({4'(1 << (g % 4)), 2'(g % 4), 1'b1, 1'b0}));
            tick();
            check($sformatf("rot%0d_c2", g), 32'(outs(0)), 32'({4'(1 << (g % 4)), 2'(g % 4), 1'b1, 1'b0}));
            done = 1'b1;
            tick();
            check($sformatf("rot%0d_idle", g), 32'({gnt_w[0], valid_w[0], tmo_w[0]}), 32'(6'b0));
        end

        // HOLD_MAX=1: a grant lasts one cycle and ends in a timeout idle cycle.
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        tick();
        rst = 1'b0; req = 4'b0100;
        tick();
        check("hm1_grant", 32'(outs(2)), 32'({4'b0100, 2'd2, 1'b1, 1'b0}));
        tick();
        check("hm1_timeout", 32'(outs(2)), 32'({4'b0000, 2'd2, 1'b0, 1'b1}));
        tick();
        check("hm1_regrant", 32'(outs(2)), 32'({4'b0100, 2'd2, 1'b1, 1'b0}));

        // Randomized run of all three instances against the model.
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) model_step(k);
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) req = req ^ 4'(1 << $urandom_range(3));
            if ($urandom_range(15) == 0) req = 4'($urandom);
            done = ($urandom_range(9) == 0);
            rst  = ($urandom_range(199) == 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                model_step(k);
                check($sformatf("rand%0d_inst%0d", n, k), 32'(outs(k)), 32'(model_outs(k)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
